// File: rtl/dehaze_pkg.sv
// Shared definitions for the dark-channel streamer: per-pixel min3 helper,
// {R,G,B} packing slots and the frame sequencer state type.
package dehaze_pkg;

    // Working width of min3; callers zero-extend their channels into it
    localparam int MIN3_W = 32;

    // Channel slot inside a packed {R,G,B} word, counted in channel widths from the LSB
    localparam int R_SLOT = 2;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned minimum of three values; on ties any equal value is correct
    function automatic logic [MIN3_W-1:0] min3(input logic [MIN3_W-1:0] a,
                                               input logic [MIN3_W-1:0] b,
                                               input logic [MIN3_W-1:0] c);
        logic [MIN3_W-1:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster read-address counter. Steps once per enabled, unpaused cycle,
// holds while paused and flags the final address of the frame.
module raster_addr_gen #(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              pause,
    output logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // A read is issued in exactly the cycles the counter advances
    assign step = enable & ~pause;
    assign last = (addr == LAST_ADDR);

    // Address register: clear on frame start, advance per issued read, wrap after the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (step) begin
            addr <= last ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/dark_channel_streamer.sv
// Dark-channel streamer: reads a WIDTH x HEIGHT {R,G,B} frame in raster
// order and emits min(R,G,B) per pixel, two cycles after each read strobe.
// Optional macro DARK_STREAM_FLUSH_EN: after the last pixel, emit WIDTH+2
// all-ones pad samples before signalling done; without it the flush phase
// only drains the read pipeline.
module dark_channel_streamer
    import dehaze_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            pause,
    output logic                            mem_rd,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] mem_addr,
    input  logic [3*DATA_WIDTH-1:0]         mem_rdata,
    output logic [DATA_WIDTH-1:0]           out_val,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);

    // Handshake: mem_rd is a strobe and mem_rdata is valid exactly one cycle
    // later; out_valid qualifies out_val for one cycle and has no back-pressure,
    // so every asserted out_valid is a consumed sample.

    state_t                state;
    logic                  rd_d1;
    logic                  step;
    logic                  last;
    logic                  pad_issue;
    logic                  pads_done;
    logic [DATA_WIDTH-1:0] r_ch;
    logic [DATA_WIDTH-1:0] g_ch;
    logic [DATA_WIDTH-1:0] b_ch;
    logic [DATA_WIDTH-1:0] pix_min;

    raster_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state == IDLE) && start),
        .enable (state == READ),
        .pause  (pause),
        .step   (step),
        .addr   (mem_addr),
        .last   (last)
    );

    assign mem_rd = step;

    assign r_ch    = mem_rdata[R_SLOT*DATA_WIDTH +: DATA_WIDTH];
    assign g_ch    = mem_rdata[G_SLOT*DATA_WIDTH +: DATA_WIDTH];
    assign b_ch    = mem_rdata[B_SLOT*DATA_WIDTH +: DATA_WIDTH];
    assign pix_min = DATA_WIDTH'(min3(MIN3_W'(r_ch), MIN3_W'(g_ch), MIN3_W'(b_ch)));

`ifdef DARK_STREAM_FLUSH_EN
    localparam int PAD_N = WIDTH + 2;
    localparam int PAD_W = $clog2(PAD_N + 1);

    logic [PAD_W-1:0] pad_cnt;

    // Pads wait for the last pixel to leave the read stage so they never interleave
    assign pad_issue = (state == FLUSH) && !rd_d1 && !pause && (pad_cnt != PAD_W'(PAD_N));
    assign pads_done = (pad_cnt == PAD_W'(PAD_N));

    // Pad counter: rearmed while idle, counts pads handed to the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_cnt <= '0;
        end else if (state == IDLE) begin
            pad_cnt <= '0;
        end else if (pad_issue) begin
            pad_cnt <= pad_cnt + PAD_W'(1);
        end
    end
`else
    assign pad_issue = 1'b0;
    assign pads_done = 1'b1;
`endif

    // Read pipeline: rdata-valid stage then registered min, zeroed when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1     <= 1'b0;
            out_valid <= 1'b0;
            out_val   <= '0;
        end else begin
            rd_d1     <= mem_rd;
            out_valid <= rd_d1 | pad_issue;
            if (rd_d1) begin
                out_val <= pix_min;
            end else if (pad_issue) begin
                out_val <= '1;
            end else begin
                out_val <= '0;
            end
        end
    end

    // Frame sequencer with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (step && last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pads_done && !rd_d1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dark_channel_streamer.md
DARK_CHANNEL_STREAMER -- requirements
Module: dark_channel_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 120, meaning lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning bits per colour channel and per output sample.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle frame start request.
REQ-007 SHALL have port pause, input, 1 bit, which inhibits new read issue while high.
REQ-008 SHALL have port mem_rd, output, 1 bit, a frame-RAM read strobe.
REQ-009 SHALL have port mem_addr, output, $clog2(WIDTH*HEIGHT) bits, the raster read address.
REQ-010 SHALL have port mem_rdata, input, 3*DATA_WIDTH bits, packed {R,G,B} valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have port out_val, output, DATA_WIDTH bits, the dark-channel sample.
REQ-012 SHALL have port out_valid, output, 1 bit, the sample qualifier; there is no ready, so the downstream always accepts.
REQ-013 SHALL have port busy, output, 1 bit, high from the accepted start until done.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement FSM states IDLE, READ, FLUSH, DONE.
REQ-016 IDLE->READ SHALL occur on start; mem_addr SHALL be cleared to 0 and busy SHALL be set on the next edge.
REQ-017 In READ, each cycle with pause low SHALL assert mem_rd at the current mem_addr and then increment it.
REQ-018 In READ with pause high, mem_rd SHALL be 0 and mem_addr SHALL hold; reads already issued SHALL still complete.
REQ-019 READ->FLUSH SHALL occur on the cycle the read at address WIDTH*HEIGHT-1 is issued.
REQ-020 Each returned word SHALL produce out_val = min(R,G,B), unsigned, with ties resolved to any equal value.
REQ-021 out_valid SHALL assert exactly 2 cycles after the corresponding mem_rd (rdata at +1, registered min at +2).
REQ-022 Output order SHALL equal issue order; gaps in mem_rd SHALL appear as identical gaps in out_valid.
REQ-023 out_val SHALL be 0 whenever out_valid is 0.
REQ-024 FLUSH, when enabled per REQ-031, SHALL emit WIDTH+2 pad samples of all-ones with out_valid high, obey pause, and issue no mem_rd.
REQ-025 FLUSH->DONE SHALL occur once the last pad is emitted and the read pipeline is empty.
REQ-026 DONE SHALL last 1 cycle, with done=1 and busy=0 on the following cycle, then return to IDLE.
REQ-027 start received while busy SHALL be ignored; start and pause asserted together SHALL still start the frame.
REQ-028 Pad samples SHALL never interleave with pixel samples; all real pixels SHALL precede the first pad.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE; mem_rd, out_valid, busy, done 0; out_val 0; mem_addr 0; pipeline valids cleared.
REQ-030 Reset mid-frame SHALL discard in-flight reads; no out_valid SHALL follow a reset until the next start.

Configuration
REQ-031 With macro DARK_STREAM_FLUSH_EN defined, FLUSH SHALL emit the pad samples; without it, FLUSH SHALL only wait for the pipeline to drain and emit no pads.

Structure
REQ-032 The package dehaze_pkg SHALL hold the min3 function, the RGB packing offsets, and the FSM state typedef.
REQ-033 The raster address counter with pause hold and terminal-count flag SHALL be the sub-module raster_addr_gen.

Verification
REQ-034 With WIDTH=4, HEIGHT=3, macro defined, and start with pause=0: mem_rd SHALL be high for 12 consecutive cycles at addr 0..11, 12 pixels SHALL follow plus 6 pads of 0xFF, and done SHALL pulse once.
REQ-035 mem_rdata {0x40,0x10,0x80} SHALL give out_val 0x10 two cycles after its mem_rd; {0x20,0x20,0x20} SHALL give 0x20.
REQ-036 pause high for 3 cycles after the 5th read SHALL give a 3-cycle out_valid gap; addresses and data SHALL stay in order with no repeats.
REQ-037 A start pulse at the 6th read SHALL be ignored: one frame, one done.
REQ-038 rst_n low at the 7th read SHALL drop busy and out_valid immediately; a later start SHALL restart from addr 0.
REQ-039 Without the macro, the same frame SHALL give exactly 12 out_valid cycles, and done SHALL follow the last pixel once the pipeline drains.
